pwm_ramp_ctrl: RTL and testbench

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

---
 rtl/pwm_ctrl_pkg.sv | 35 +++
 rtl/ramp_tick_gen.sv | 40 ++++
 rtl/pwm_ramp_ctrl.sv | 126 ++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pwm_ctrl_pkg
// Shared definitions for the PWM ramp controller:
//   - state_t : ramp controller states (OFF, RAMP, HOLD, STOP)
//   - SPEED_W : width of the applied speed level
//   - TICK_W  : width of the ramp-step tick counter
// -----------------------------------------------------------------------------
package pwm_ctrl_pkg;

    localparam int SPEED_W = 3;
    localparam int TICK_W  = 16;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2,
        STOP = 2'd3
    } state_t;

    // One level toward goal; returns cur unchanged when already there.
    function automatic logic [SPEED_W-1:0] step_toward(
        input logic [SPEED_W-1:0] cur,
        input logic [SPEED_W-1:0] goal
    );
        logic [SPEED_W-1:0] res;
        res = cur;
        if (goal > cur) begin
            res = cur + 1'b1;
        end else if (goal < cur) begin
            res = cur - 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// -----------------------------------------------------------------------------
// ramp_tick_gen
// Ramp-step timebase. Counts 0..TICK_DIV-1 while run is high and fires tick
// in the cycle the count equals TICK_DIV-1, then wraps to 0.
// Ports:
//   clk   in  clock
//   rst_n in  asynchronous active-low reset
//   run   in  count enable (controller is in RAMP or STOP)
//   clear in  synchronous clear of the count (has priority over run)
//   tick  out ramp-step strobe, one cycle wide
// -----------------------------------------------------------------------------
module ramp_tick_gen
    import pwm_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_ramp_ctrl
// Soft-start / soft-stop controller for a PWM datapath. The applied speed
// level moves one step per ramp tick toward the requested target, and ramps
// down to zero before the PWM is disabled.
// Ports:
//   clk       in  clock
//   rst_n     in  asynchronous active-low reset
//   en_req    in  1 = run toward target, 0 = ramp down and stop
//   target    in  requested speed level 0..7
//   pwm_en    out PWM datapath enable (high in RAMP, HOLD, STOP)
//   speed     out applied speed level (registered)
//   busy      out ramp step pending (RAMP or STOP)
//   at_target out steady at the requested level (HOLD)
// -----------------------------------------------------------------------------
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_req,
    input  logic [SPEED_W-1:0] target,
    output logic               pwm_en,
    output logic [SPEED_W-1:0] speed,
    output logic               busy,
    output logic               at_target
);

    generate
        if (TICK_DIV < 2 || TICK_DIV > 65535) begin : g_bad_div
            $error("pwm_ramp_ctrl: TICK_DIV out of range 2..65535");
        end
    endgenerate

    state_t             state;
    state_t             state_nxt;
    logic [SPEED_W-1:0] cur;
    logic [SPEED_W-1:0] cur_nxt;
    logic               tick;
    logic               tick_run;
    logic               tick_clear;

    // Counter runs only while a step is pending. Holding it cleared in OFF
    // and HOLD means every entry into RAMP/STOP from those states starts at 0,
    // while RAMP<->STOP hand-overs keep the phase of the current step.
    assign tick_run   = (state == RAMP) || (state == STOP);
    assign tick_clear = (state == OFF)  || (state == HOLD);

    ramp_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (tick_run),
        .clear (tick_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OFF;
            cur   <= '0;
        end else begin
            state <= state_nxt;
            cur   <= cur_nxt;
        end
    end

    // The step for this cycle is computed first; transitions are then
    // decided on the stepped level so a tick and a request change in the
    // same cycle resolve consistently.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        case (state)
            OFF: begin
                cur_nxt = '0;
                if (en_req) begin
                    state_nxt = (target != '0) ? RAMP : HOLD;
                end
            end
            RAMP: begin
                if (tick) begin
                    cur_nxt = step_toward(cur, target);
                end
                if (!en_req) begin
                    // Already at zero: nothing left to ramp down.
                    state_nxt = (cur_nxt == '0) ? OFF : STOP;
                end else if (tick && (cur_nxt == target)) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!en_req) begin
                    state_nxt = (cur == '0) ? OFF : STOP;
                end else if (target != cur) begin
                    state_nxt = RAMP;
                end
            end
            STOP: begin
                if (tick && (cur != '0)) begin
                    cur_nxt = cur - 1'b1;
                end
                if (en_req) begin
                    state_nxt = RAMP;
                end else if (cur_nxt == '0) begin
                    state_nxt = OFF;
                end
            end
            default: begin
                state_nxt = OFF;
                cur_nxt   = '0;
            end
        endcase
    end

    // Outputs decode registered state only; no input reaches an output
    // without passing a flop.
    assign speed     = cur;
    assign pwm_en    = (state != OFF);
    assign busy      = (state == RAMP) || (state == STOP);
    assign at_target = (state == HOLD);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
module tb_pwm_ramp_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en_req;
    logic [2:0] target;
    logic       pwm_en;
    logic [2:0] speed;
    logic       busy;
    logic       at_target;

    int checks = 0;
    int errors = 0;

    pwm_ramp_ctrl #(
        .TICK_DIV (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_req    (en_req),
        .target    (target),
        .pwm_en    (pwm_en),
        .speed     (speed),
        .busy      (busy),
        .at_target (at_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        en_req = 1'b0;
        target = 3'd0;
        #2;
        chk("rst_pwm_en", {7'd0, pwm_en}, 8'd0);
        chk("rst_speed", {5'd0, speed}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_at_target", {7'd0, at_target}, 8'd0);

        // Ramp up 0 -> 5
        cyc(2);
        rst_n  = 1'b1;
        en_req = 1'b1;
        target = 3'd5;
        cyc(1);
        chk("up_entry_busy", {7'd0, busy}, 8'd1);
        chk("up_entry_pwm_en", {7'd0, pwm_en}, 8'd1);
        chk("up_entry_speed", {5'd0, speed}, 8'd0);
        for (int lvl = 1; lvl <= 5; lvl++) begin
            cyc(3);
            chk("up_before_step", {5'd0, speed}, 8'(lvl - 1));
            cyc(1);
            chk("up_step", {5'd0, speed}, 8'(lvl));
        end
        chk("up_at_target", {7'd0, at_target}, 8'd1);
        chk("up_busy_done", {7'd0, busy}, 8'd0);

        // Ramp down 5 -> 0 and off
        en_req = 1'b0;
        cyc(1);
        chk("dn_entry_busy", {7'd0, busy}, 8'd1);
        chk("dn_entry_speed", {5'd0, speed}, 8'd5);
        chk("dn_entry_at_target", {7'd0, at_target}, 8'd0);
        for (int lvl = 4; lvl >= 0; lvl--) begin
            cyc(3);
            chk("dn_before_step", {5'd0, speed}, 8'(lvl + 1));
            cyc(1);
            chk("dn_step", {5'd0, speed}, 8'(lvl));
            chk("dn_pwm_en", {7'd0, pwm_en}, (lvl != 0) ? 8'd1 : 8'd0);
        end
        chk("dn_busy_off", {7'd0, busy}, 8'd0);

        // Ramp toward 6, reverse to 2 at speed 4
        en_req = 1'b1;
        target = 3'd6;
        cyc(1);
        for (int lvl = 1; lvl <= 4; lvl++) begin
            cyc(4);
            chk("rev_up_step", {5'd0, speed}, 8'(lvl));
        end
        target = 3'd2;
        cyc(3);
        chk("rev_no_overshoot", {5'd0, speed}, 8'd4);
        cyc(1);
        chk("rev_step3", {5'd0, speed}, 8'd3);
        cyc(4);
        chk("rev_step2", {5'd0, speed}, 8'd2);
        chk("rev_at_target", {7'd0, at_target}, 8'd1);
        chk("rev_busy", {7'd0, busy}, 8'd0);

        // HOLD 2 -> 4, then STOP to 3, then resume toward 7 mid-period
        target = 3'd4;
        cyc(1);
        chk("res_ramp_busy", {7'd0, busy}, 8'd1);
        cyc(4);
        chk("res_up3", {5'd0, speed}, 8'd3);
        cyc(4);
        chk("res_up4", {5'd0, speed}, 8'd4);
        chk("res_hold4", {7'd0, at_target}, 8'd1);
        en_req = 1'b0;
        cyc(1);
        chk("res_stop_busy", {7'd0, busy}, 8'd1);
        cyc(4);
        chk("res_stop3", {5'd0, speed}, 8'd3);
        cyc(2);
        en_req = 1'b1;
        target = 3'd7;
        cyc(1);
        chk("res_switch_speed", {5'd0, speed}, 8'd3);
        chk("res_switch_busy", {7'd0, busy}, 8'd1);
        cyc(1);
        chk("res_no_clear_step4", {5'd0, speed}, 8'd4);
        for (int lvl = 5; lvl <= 7; lvl++) begin
            cyc(4);
            chk("res_up_step", {5'd0, speed}, 8'(lvl));
        end
        chk("res_at_target7", {7'd0, at_target}, 8'd1);

        // Async reset mid-ramp at speed 3
        target = 3'd2;
        cyc(1);
        for (int lvl = 6; lvl >= 3; lvl--) begin
            cyc(4);
            chk("ar_down_step", {5'd0, speed}, 8'(lvl));
        end
        cyc(1);
        chk("ar_pre_busy", {7'd0, busy}, 8'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_speed", {5'd0, speed}, 8'd0);
        chk("ar_pwm_en", {7'd0, pwm_en}, 8'd0);
        chk("ar_busy", {7'd0, busy}, 8'd0);
        chk("ar_at_target", {7'd0, at_target}, 8'd0);
        en_req = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        chk("ar_after_pwm_en", {7'd0, pwm_en}, 8'd0);
        chk("ar_after_speed", {5'd0, speed}, 8'd0);

        // Enable with target 0: straight to HOLD, never busy
        en_req = 1'b1;
        target = 3'd0;
        cyc(1);
        chk("z_pwm_en", {7'd0, pwm_en}, 8'd1);
        chk("z_speed", {5'd0, speed}, 8'd0);
        chk("z_at_target", {7'd0, at_target}, 8'd1);
        chk("z_busy", {7'd0, busy}, 8'd0);
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk("z_busy_hold", {7'd0, busy}, 8'd0);
        end
        en_req = 1'b0;
        cyc(1);
        chk("z_off_pwm_en", {7'd0, pwm_en}, 8'd0);
        chk("z_off_at_target", {7'd0, at_target}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
